bf128_sched_ctrl: RTL and testbench

- Sequencer for the Blowfish-128 datapath: owns the `skeygen` subkey generator and the block round core.
- Accepts key-load requests, runs subkey generation, then admits 128-bit block requests one at a time and returns results through a ready/valid output.
- If a block asks for a different direction (encrypt/decrypt) than the loaded subkey order, it re-runs key generation automatically before admitting that block.
- Sits between the host interface and the `skeygen` + round-core pair in the Blowfish-128 top level.

---
 rtl/bf128_pkg.sv | 28 ++
 rtl/bf128_timeout_cnt.sv | 35 +++
 rtl/bf128_sched_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_bf128_sched_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bf128_pkg.sv
// Shared types and constants for the Blowfish-128 sequencer.
package bf128_pkg;

  localparam int unsigned BLK_W       = 128;
  localparam int unsigned KEY_LEN_W   = 4;
  localparam int unsigned ERR_W       = 2;
  localparam int unsigned KEY_LEN_MIN = 1;
  localparam int unsigned KEY_LEN_MAX = 8;

  typedef enum logic [2:0] {
    ST_NOKEY  = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_GAP    = 3'd2,
    ST_LOADED = 3'd3,
    ST_RUN    = 3'd4,
    ST_REGEN  = 3'd5
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_KEYLEN  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_SKG_TO  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_CORE_TO = 2'd3;

  function automatic logic key_len_ok(input logic [KEY_LEN_W-1:0] len);
    return (len >= KEY_LEN_W'(KEY_LEN_MIN)) && (len <= KEY_LEN_W'(KEY_LEN_MAX));
  endfunction

endpackage

// File: rtl/bf128_timeout_cnt.sv
// Saturating cycle counter; expired_c is high once the count reaches limit_i.
module bf128_timeout_cnt #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q < limit_i)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q >= limit_i);

endmodule

// File: rtl/bf128_sched_ctrl.sv
// Sequences key generation and single-block processing for the Blowfish-128
// datapath, re-running subkey generation when a block needs the other order.
module bf128_sched_ctrl
  import bf128_pkg::*;
#(
  parameter int unsigned SKG_TIMEOUT  = 4096,
  parameter int unsigned CORE_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [KEY_LEN_W-1:0] key_length,
  input  logic                 key_encrypt,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic                 blk_encrypt,
  input  logic [BLK_W-1:0]     blk_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLK_W-1:0]     out_data,
  output logic                 skg_enable,
  output logic                 skg_encrypt,
  output logic [KEY_LEN_W-1:0] skg_key_length,
  input  logic                 skg_ready,
  output logic                 core_start,
  output logic [BLK_W-1:0]     core_din,
  output logic                 core_encrypt,
  input  logic                 core_done,
  input  logic [BLK_W-1:0]     core_dout,
  output logic                 keys_loaded,
  output logic                 err,
  output logic [ERR_W-1:0]     err_code
);

  localparam int unsigned SKG_CW  = $clog2(SKG_TIMEOUT + 1);
  localparam int unsigned CORE_CW = $clog2(CORE_TIMEOUT + 1);

  state_e state_q, state_d;

  logic                 skg_enable_q, skg_enable_d;
  logic                 skg_encrypt_q, skg_encrypt_d;
  logic [KEY_LEN_W-1:0] skg_key_length_q, skg_key_length_d;
  logic                 core_start_q, core_start_d;
  logic [BLK_W-1:0]     core_din_q, core_din_d;
  logic                 core_encrypt_q, core_encrypt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BLK_W-1:0]     out_data_q, out_data_d;
  logic                 keys_loaded_q, keys_loaded_d;
  logic                 err_q, err_d;
  logic [ERR_W-1:0]     err_code_q, err_code_d;

  logic in_loaded, in_skg, in_run;
  logic key_acc, key_bad, blk_match, blk_acc, blk_mis;
  logic skg_to, core_to;

  assign in_loaded = (state_q == ST_LOADED);
  assign in_skg    = (state_q == ST_KEYGEN) || (state_q == ST_REGEN);
  assign in_run    = (state_q == ST_RUN);

  // Key requests take priority over blocks; a direction mismatch drops blk_ready at once.
  assign key_ready = ~rst & ((state_q == ST_NOKEY) | in_loaded);
  assign key_acc   = key_valid & key_ready;
  assign key_bad   = ~key_len_ok(key_length);
  assign blk_match = (blk_encrypt == skg_encrypt_q);
  assign blk_ready = in_loaded & ~out_valid_q & ~key_valid & blk_match;
  assign blk_acc   = blk_valid & blk_ready;
  assign blk_mis   = in_loaded & blk_valid & ~key_valid & ~out_valid_q & ~blk_match;

  bf128_timeout_cnt #(.W(SKG_CW)) u_skg_to (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~in_skg),
    .en_i      (in_skg),
    .limit_i   (SKG_CW'(SKG_TIMEOUT)),
    .expired_c (skg_to)
  );

  bf128_timeout_cnt #(.W(CORE_CW)) u_core_to (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~in_run),
    .en_i      (in_run),
    .limit_i   (CORE_CW'(CORE_TIMEOUT)),
    .expired_c (core_to)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_NOKEY;
      skg_enable_q     <= 1'b0;
      skg_encrypt_q    <= 1'b0;
      skg_key_length_q <= '0;
      core_start_q     <= 1'b0;
      core_din_q       <= '0;
      core_encrypt_q   <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      keys_loaded_q    <= 1'b0;
      err_q            <= 1'b0;
      err_code_q       <= ERR_NONE;
    end else begin
      state_q          <= state_d;
      skg_enable_q     <= skg_enable_d;
      skg_encrypt_q    <= skg_encrypt_d;
      skg_key_length_q <= skg_key_length_d;
      core_start_q     <= core_start_d;
      core_din_q       <= core_din_d;
      core_encrypt_q   <= core_encrypt_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      keys_loaded_q    <= keys_loaded_d;
      err_q            <= err_d;
      err_code_q       <= err_code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NOKEY: begin
        if (key_acc) state_d = key_bad ? ST_NOKEY : ST_KEYGEN;
      end
      ST_KEYGEN, ST_REGEN: begin
        if (skg_ready)   state_d = ST_GAP;
        else if (skg_to) state_d = ST_NOKEY;
      end
      ST_GAP: state_d = ST_LOADED;
      ST_LOADED: begin
        if (key_acc)      state_d = key_bad ? ST_NOKEY : ST_KEYGEN;
        else if (blk_acc) state_d = ST_RUN;
        else if (blk_mis) state_d = ST_REGEN;
      end
      ST_RUN: begin
        if (core_done || core_to) state_d = ST_LOADED;
      end
      default: state_d = ST_NOKEY;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    skg_enable_d     = skg_enable_q;
    skg_encrypt_d    = skg_encrypt_q;
    skg_key_length_d = skg_key_length_q;
    core_start_d     = 1'b0;
    core_din_d       = core_din_q;
    core_encrypt_d   = core_encrypt_q;
    out_valid_d      = out_valid_q & ~out_ready;
    out_data_d       = out_data_q;
    keys_loaded_d    = keys_loaded_q;
    err_d            = err_q;
    err_code_d       = err_code_q;

    if (key_acc) begin
      skg_key_length_d = key_length;
      skg_encrypt_d    = key_encrypt;
      skg_enable_d     = ~key_bad;
      keys_loaded_d    = 1'b0;
      err_d            = key_bad;
      err_code_d       = key_bad ? ERR_KEYLEN : ERR_NONE;
    end else if (blk_acc) begin
      core_din_d     = blk_in;
      core_encrypt_d = blk_encrypt;
      core_start_d   = 1'b1;
    end else if (blk_mis) begin
      skg_encrypt_d = blk_encrypt;
      skg_enable_d  = 1'b1;
      keys_loaded_d = 1'b0;
    end

    case (state_q)
      ST_KEYGEN, ST_REGEN: begin
        if (skg_ready) begin
          skg_enable_d = 1'b0;
        end else if (skg_to) begin
          skg_enable_d = 1'b0;
          err_d        = 1'b1;
          err_code_d   = ERR_SKG_TO;
        end
      end
      ST_GAP: keys_loaded_d = 1'b1;
      ST_RUN: begin
        if (core_done) begin
          out_data_d  = core_dout;
          out_valid_d = 1'b1;
        end else if (core_to) begin
          err_d      = 1'b1;
          err_code_d = ERR_CORE_TO;
        end
      end
      default: ;
    endcase
  end

  assign skg_enable     = skg_enable_q;
  assign skg_encrypt    = skg_encrypt_q;
  assign skg_key_length = skg_key_length_q;
  assign core_start     = core_start_q;
  assign core_din       = core_din_q;
  assign core_encrypt   = core_encrypt_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign keys_loaded    = keys_loaded_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_bf128_sched_ctrl.sv
// Directed bench for bf128_sched_ctrl: key load, block path, direction switch,
// illegal keys, backpressure, timeouts and asynchronous reset.
module tb_bf128_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, key_ready;
  logic [3:0]   key_length;
  logic         key_encrypt;
  logic         blk_valid, blk_ready, blk_encrypt;
  logic [127:0] blk_in;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         skg_enable, skg_encrypt;
  logic [3:0]   skg_key_length;
  logic         skg_ready;
  logic         core_start;
  logic [127:0] core_din;
  logic         core_encrypt, core_done;
  logic [127:0] core_dout;
  logic         keys_loaded, err;
  logic [1:0]   err_code;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [127:0] V1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] V2 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] R1 = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;

  always #5 clk = ~clk;

  bf128_sched_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .key_length     (key_length),
    .key_encrypt    (key_encrypt),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_encrypt    (blk_encrypt),
    .blk_in         (blk_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .skg_enable     (skg_enable),
    .skg_encrypt    (skg_encrypt),
    .skg_key_length (skg_key_length),
    .skg_ready      (skg_ready),
    .core_start     (core_start),
    .core_din       (core_din),
    .core_encrypt   (core_encrypt),
    .core_done      (core_done),
    .core_dout      (core_dout),
    .keys_loaded    (keys_loaded),
    .err            (err),
    .err_code       (err_code)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_length = 4'd0; key_encrypt = 1'b0;
    blk_valid = 1'b0; blk_encrypt = 1'b0; blk_in = '0; out_ready = 1'b0;
    skg_ready = 1'b0; core_done = 1'b0; core_dout = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_skg_enable", skg_enable, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_keys_loaded", keys_loaded, 0);
    chk("rst_blk_ready", blk_ready, 0);
    rst = 1'b0;
    #1;
    chk("nokey_key_ready", key_ready, 1);
    chk("nokey_blk_ready", blk_ready, 0);

    // Key load: length 4, encrypt
    @(negedge clk);
    key_valid = 1'b1; key_length = 4'd4; key_encrypt = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("kg_skg_enable", skg_enable, 1);
    chk("kg_skg_encrypt", skg_encrypt, 1);
    chk("kg_skg_len", skg_key_length, 4);
    chk("kg_key_ready", key_ready, 0);
    chk("kg_keys_loaded", keys_loaded, 0);
    repeat (3) @(negedge clk);
    chk("kg_hold_enable", skg_enable, 1);
    skg_ready = 1'b1;
    @(negedge clk);
    skg_ready = 1'b0;
    chk("gap_skg_enable", skg_enable, 0);
    chk("gap_keys_loaded", keys_loaded, 0);
    @(negedge clk);
    chk("ld_keys_loaded", keys_loaded, 1);
    chk("ld_err", err, 0);
    chk("ld_key_ready", key_ready, 1);

    // Block round trip, core answers 17 cycles after accept
    blk_valid = 1'b1; blk_encrypt = 1'b1; blk_in = V1;
    #1;
    chk("blk_ready_match", blk_ready, 1);
    @(negedge clk);
    blk_valid = 1'b0;
    chk("rt_core_start", core_start, 1);
    chk("rt_core_din", core_din, V1);
    chk("rt_core_encrypt", core_encrypt, 1);
    chk("rt_key_ready", key_ready, 0);
    @(negedge clk);
    chk("rt_core_start_pulse", core_start, 0);
    repeat (15) @(negedge clk);
    core_done = 1'b1; core_dout = R1;
    @(negedge clk);
    core_done = 1'b0; core_dout = '0;
    chk("rt_out_valid", out_valid, 1);
    chk("rt_out_data", out_data, R1);
    chk("rt_keys_loaded", keys_loaded, 1);

    // Backpressure: result held, no new block accepted
    blk_valid = 1'b1; blk_encrypt = 1'b1; blk_in = V2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_data", out_data, R1);
      chk("bp_blk_ready", blk_ready, 0);
    end
    chk("bp_core_start", core_start, 0);
    out_ready = 1'b1; blk_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_valid_clr", out_valid, 0);

    // Key and block contend: key wins
    key_valid = 1'b1; key_length = 4'd2; key_encrypt = 1'b1;
    blk_valid = 1'b1; blk_encrypt = 1'b1;
    #1;
    chk("ct_blk_ready", blk_ready, 0);
    chk("ct_key_ready", key_ready, 1);
    @(negedge clk);
    key_valid = 1'b0; blk_valid = 1'b0;
    chk("ct_skg_enable", skg_enable, 1);
    chk("ct_skg_len", skg_key_length, 2);
    chk("ct_core_start", core_start, 0);
    skg_ready = 1'b1;
    @(negedge clk);
    skg_ready = 1'b0;
    @(negedge clk);
    chk("ct_keys_loaded", keys_loaded, 1);

    // Direction switch: decrypt block against encrypt subkeys
    blk_valid = 1'b1; blk_encrypt = 1'b0; blk_in = V2;
    #1;
    chk("ds_blk_ready_mis", blk_ready, 0);
    @(negedge clk);
    chk("ds_skg_encrypt", skg_encrypt, 0);
    chk("ds_skg_enable", skg_enable, 1);
    chk("ds_keys_loaded", keys_loaded, 0);
    chk("ds_core_start", core_start, 0);
    skg_ready = 1'b1;
    @(negedge clk);
    skg_ready = 1'b0;
    chk("ds_gap_blk_ready", blk_ready, 0);
    @(negedge clk);
    chk("ds_ld_blk_ready", blk_ready, 1);
    chk("ds_ld_keys_loaded", keys_loaded, 1);
    @(negedge clk);
    blk_valid = 1'b0;
    chk("ds_core_start_acc", core_start, 1);
    chk("ds_core_encrypt", core_encrypt, 0);
    chk("ds_core_din", core_din, V2);

    // Core timeout: no core_done for this block
    repeat (256) @(negedge clk);
    chk("cto_err_early", err, 0);
    chk("cto_key_ready_early", key_ready, 0);
    @(negedge clk);
    chk("cto_err", err, 1);
    chk("cto_err_code", err_code, 3);
    chk("cto_out_valid", out_valid, 0);
    chk("cto_key_ready", key_ready, 1);

    // Illegal key lengths 0 and 9
    key_valid = 1'b1; key_length = 4'd0; key_encrypt = 1'b1;
    @(negedge clk);
    chk("il0_err", err, 1);
    chk("il0_err_code", err_code, 1);
    chk("il0_skg_enable", skg_enable, 0);
    chk("il0_keys_loaded", keys_loaded, 0);
    chk("il0_blk_ready", blk_ready, 0);
    key_length = 4'd9;
    @(negedge clk);
    key_valid = 1'b0;
    chk("il9_err_code", err_code, 1);
    chk("il9_skg_enable", skg_enable, 0);
    @(negedge clk);
    chk("il9_skg_enable_late", skg_enable, 0);
    chk("il9_key_ready", key_ready, 1);

    // Skeygen timeout: skg_ready never arrives
    key_valid = 1'b1; key_length = 4'd8; key_encrypt = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("sto_err_cleared", err, 0);
    chk("sto_err_code_cleared", err_code, 0);
    chk("sto_skg_enable", skg_enable, 1);
    repeat (4096) @(negedge clk);
    chk("sto_err_early", err, 0);
    chk("sto_enable_early", skg_enable, 1);
    @(negedge clk);
    chk("sto_err", err, 1);
    chk("sto_err_code", err_code, 2);
    chk("sto_skg_enable", skg_enable, 0);
    chk("sto_key_ready", key_ready, 1);

    // Asynchronous reset in the middle of RUN
    key_valid = 1'b1; key_length = 4'd1; key_encrypt = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; skg_ready = 1'b1;
    @(negedge clk);
    skg_ready = 1'b0;
    @(negedge clk);
    blk_valid = 1'b1; blk_encrypt = 1'b1; blk_in = V1;
    @(negedge clk);
    blk_valid = 1'b0;
    chk("rr_core_start", core_start, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rr_core_start_rst", core_start, 0);
    chk("rr_core_din", core_din, 0);
    chk("rr_core_encrypt", core_encrypt, 0);
    chk("rr_out_valid", out_valid, 0);
    chk("rr_keys_loaded", keys_loaded, 0);
    chk("rr_skg_encrypt", skg_encrypt, 0);
    chk("rr_skg_len", skg_key_length, 0);
    chk("rr_key_ready", key_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_nokey_key_ready", key_ready, 1);
    chk("rr_nokey_blk_ready", blk_ready, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
